// File: rtl/bf_program_loader.sv
// bf_program_loader: encodes a streamed Brainfuck source into 3-bit opcodes written
// sequentially into program RAM, tracking bracket balance and program length.
module bf_program_loader #(
    parameter int          ADDR_W    = 10,
    parameter int          DEPTH     = 1024,
    parameter logic [7:0]  TERM_CHAR = 8'h21,
    parameter int          NEST_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [2:0]        wr_code,
    output logic [ADDR_W:0]   prog_len,
    output logic              busy,
    output logic              done,
    output logic              err_overflow,
    output logic              err_bracket
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t              state_q, state_d;
    logic [ADDR_W:0]     addr_q, addr_d, prog_len_q, prog_len_d;
    logic [NEST_W-1:0]   nest_q, nest_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [2:0]          wr_code_q, wr_code_d, code;
    logic                err_ov_q, err_ov_d, err_br_q, err_br_d;
    logic                is_cmd, is_open, is_close;

    always_comb begin
        is_open  = in_data == 8'h5B;
        is_close = in_data == 8'h5D;
        is_cmd   = 1'b1;
        code     = 3'b000;
        case (in_data)
            8'h2B:   code = 3'b111;
            8'h2D:   code = 3'b110;
            8'h3E:   code = 3'b101;
            8'h3C:   code = 3'b100;
            8'h5B:   code = 3'b011;
            8'h5D:   code = 3'b010;
            8'h2E:   code = 3'b001;
            8'h2C:   code = 3'b000;
            default: is_cmd = 1'b0;
        endcase
    end

    // start has priority over a byte presented on the same edge
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        nest_d     = nest_q;
        prog_len_d = prog_len_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_code_d  = wr_code_q;
        err_ov_d   = err_ov_q;
        err_br_d   = err_br_q;
        if (start) begin
            state_d    = LOAD;
            addr_d     = '0;
            nest_d     = '0;
            prog_len_d = '0;
            err_ov_d   = 1'b0;
            err_br_d   = 1'b0;
        end else if (in_valid && state_q == LOAD) begin
            if (in_data == TERM_CHAR) begin
                state_d    = (nest_q == '0) ? DONE : ERROR;
                prog_len_d = (nest_q == '0) ? addr_q : prog_len_q;
                err_br_d   = nest_q != '0;
            end else if (is_cmd) begin
                if (addr_q == DEPTH_L) begin
                    state_d  = ERROR;
                    err_ov_d = 1'b1;
                end else if ((is_close && nest_q == '0) || (is_open && &nest_q)) begin
                    state_d  = ERROR;
                    err_br_d = 1'b1;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q[ADDR_W-1:0];
                    wr_code_d = code;
                    addr_d    = addr_q + (ADDR_W+1)'(1);
                    nest_d    = is_open ? nest_q + NEST_W'(1) : is_close ? nest_q - NEST_W'(1) : nest_q;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            nest_q     <= '0;
            prog_len_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_code_q  <= '0;
            err_ov_q   <= 1'b0;
            err_br_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            nest_q     <= nest_d;
            prog_len_q <= prog_len_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_code_q  <= wr_code_d;
            err_ov_q   <= err_ov_d;
            err_br_q   <= err_br_d;
        end
    end

    assign in_ready     = state_q == LOAD;
    assign busy         = state_q == LOAD;
    assign done         = state_q == DONE;
    assign err_overflow = err_ov_q;
    assign err_bracket  = err_br_q;
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_code      = wr_code_q;
    assign prog_len     = prog_len_q;
endmodule

// File: tb/tb_bf_program_loader.sv
// tb_bf_program_loader: directed and random source streams checked against a
// string-level reference model of the loader (small DEPTH/NEST_W to reach limits).
module tb_bf_program_loader;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;
    localparam int NEST_W = 2;
    localparam int NMAX   = 3;

    logic              clk = 0, rst = 1, start = 0, in_valid = 0;
    logic [7:0]        in_data = 0;
    logic              in_ready, wr_en, busy, done, err_overflow, err_bracket;
    logic [ADDR_W-1:0] wr_addr;
    logic [2:0]        wr_code;
    logic [ADDR_W:0]   prog_len;

    int ncmp = 0, nerr = 0;
    int wq[$];
    int exp_codes[$];
    int exp_st, exp_len, n_use;
    string ops = ",.][<>-+";

    bf_program_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .TERM_CHAR(8'h21), .NEST_W(NEST_W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_code(wr_code),
        .prog_len(prog_len), .busy(busy), .done(done),
        .err_overflow(err_overflow), .err_bracket(err_bracket)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wr_en === 1'b1) wq.push_back(int'(wr_addr) * 8 + int'(wr_code));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // exp_st: 0 still loading, 1 done, 2 overflow, 3 bracket error
    task automatic model(input string s);
        int dep = 0;
        exp_codes.delete();
        exp_st = 0;
        n_use = s.len();
        for (int i = 0; i < s.len(); i++) begin
            byte c = s[i];
            int k = -1;
            for (int j = 0; j < 8; j++) if (c == ops[j]) k = j;
            if (c == "!") begin
                exp_st = (dep == 0) ? 1 : 3;
                n_use = i + 1;
                break;
            end
            if (k < 0) continue;
            if (exp_codes.size() == DEPTH) begin
                exp_st = 2;
                n_use = i + 1;
                break;
            end
            if ((k == 2 && dep == 0) || (k == 3 && dep == NMAX)) begin
                exp_st = 3;
                n_use = i + 1;
                break;
            end
            exp_codes.push_back(k);
            dep += (k == 3) ? 1 : (k == 2) ? -1 : 0;
        end
        exp_len = (exp_st == 1) ? exp_codes.size() : 0;
    endtask

    task automatic run(input string tag, input string s, input int maxgap);
        model(s);
        @(negedge clk);
        start = 1;
        wq.delete();
        @(negedge clk);
        start = 0;
        chk({tag, ":start_busy"}, busy, 1);
        chk({tag, ":start_flags"}, {done, err_overflow, err_bracket}, 0);
        for (int i = 0; i < n_use; i++) begin
            repeat ($urandom_range(0, maxgap)) @(negedge clk);
            in_valid = 1;
            in_data = s[i];
            @(posedge clk);
            #1 in_valid = 0;
        end
        repeat (2) @(negedge clk);
        chk({tag, ":nwrites"}, wq.size(), exp_codes.size());
        for (int i = 0; i < exp_codes.size() && i < wq.size(); i++)
            chk($sformatf("%s:write%0d", tag, i), wq[i], i * 8 + exp_codes[i]);
        chk({tag, ":done"}, done, exp_st == 1);
        chk({tag, ":err_overflow"}, err_overflow, exp_st == 2);
        chk({tag, ":err_bracket"}, err_bracket, exp_st == 3);
        chk({tag, ":prog_len"}, prog_len, exp_len);
        chk({tag, ":in_ready"}, in_ready, exp_st == 0);
    endtask

    initial begin
        string s, alph;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {in_ready, wr_en, wr_addr, wr_code, prog_len, busy, done, err_overflow, err_bracket}, 0);
        rst = 0;
        @(negedge clk);
        chk("idle_ready", in_ready, 0);

        run("basic", "++>[-].!", 0);
        run("comments", "a+ \n-x!", 0);
        run("open_unmatched", "[[]!", 0);
        run("close_unmatched", "]", 0);
        run("overflow", "+++++++++!", 0);
        run("full", "++++++++!", 0);
        run("nest_overflow", "[[[[", 0);
        run("gaps", "++>[-].!", 4);

        @(negedge clk);
        start = 1;
        in_valid = 1;
        in_data = "+";
        wq.delete();
        @(negedge clk);
        start = 0;
        in_valid = 0;
        in_valid = 1;
        in_data = "!";
        @(posedge clk);
        #1 in_valid = 0;
        repeat (2) @(negedge clk);
        chk("start_wins:done", done, 1);
        chk("start_wins:prog_len", prog_len, 0);
        chk("start_wins:nwrites", wq.size(), 0);

        alph = "+-<>[].,a [[]]";
        for (int r = 0; r < 25; r++) begin
            s = "";
            repeat ($urandom_range(1, 14)) begin
                int k = $urandom_range(0, alph.len() - 1);
                s = {s, alph.substr(k, k)};
            end
            s = {s, "!"};
            run($sformatf("rnd%0d", r), s, 3);
        end

        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        foreach (ops[j]) if (j < 3) begin
            in_valid = 1;
            in_data = (j == 0) ? "+" : (j == 1) ? "[" : "-";
            @(posedge clk);
        end
        #1 in_valid = 0;
        rst = 1;
        #1;
        chk("midreset_outputs", {in_ready, wr_en, wr_addr, wr_code, prog_len, busy, done, err_overflow, err_bracket}, 0);
        @(negedge clk);
        rst = 0;
        wq.delete();
        in_valid = 1;
        in_data = "+";
        repeat (3) begin
            @(negedge clk);
            chk("midreset_ready", in_ready, 0);
            chk("midreset_wr_en", wr_en, 0);
        end
        in_valid = 0;
        chk("midreset_nwrites", wq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
